// File: rtl/lbdr_pkg.sv
// Shared encodings for the LBDR routing unit: flit types, FSM states and
// port bit positions in the 5-bit request vector {L,S,W,E,N}.
package lbdr_pkg;
  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] BODY   = 3'b010;
  localparam logic [2:0] TAIL   = 3'b100;

  typedef enum logic [1:0] {IDLE, HOLD, LAST} state_t;

  localparam int N = 0;
  localparam int E = 1;
  localparam int W = 2;
  localparam int S = 3;
  localparam int L = 4;
endpackage

// File: rtl/lbdr_route_comb.sv
// Combinational LBDR route computation: minimal adaptive requests, with an
// optional single-port deroute when no minimal port is usable.
module lbdr_route_comb
  import lbdr_pkg::*;
#(
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter bit DEROUTE_EN = 1'b1
) (
  input  logic [X_W+Y_W-1:0] dst,
  input  logic [X_W+Y_W-1:0] cur,
  input  logic [7:0]         rxy,
  input  logic [3:0]         cx,
  input  logic [3:0]         dr,
  output logic [4:0]         ports,
  output logic               unroutable
);
  logic [X_W-1:0] xd, xc;
  logic [Y_W-1:0] yd, yc;
  logic           n1, s1, e1, w1, here;
  logic [3:0]     mins, mask, der;

  assign xd = dst[X_W-1:0];
  assign yd = dst[X_W+Y_W-1:X_W];
  assign xc = cur[X_W-1:0];
  assign yc = cur[X_W+Y_W-1:X_W];

  assign n1   = yd < yc;
  assign s1   = yc < yd;
  assign e1   = xc < xd;
  assign w1   = xd < xc;
  assign here = ~n1 & ~s1 & ~e1 & ~w1;

  // rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, cx = {Cs,Cw,Ce,Cn}
  assign mins[N] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
  assign mins[E] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
  assign mins[W] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
  assign mins[S] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];

  generate
    if (DEROUTE_EN) begin : g_der
      assign mask = dr & cx;
    end else begin : g_noder
      logic unused_dr;
      assign unused_dr = ^dr;
      assign mask      = 4'b0000;
    end
  endgenerate

  // isolate lowest set bit: N has priority, then E, W, S
  assign der = mask & (~mask + 4'd1);

  always_comb begin
    ports      = '0;
    unroutable = 1'b0;
    if (here)          ports[L]   = 1'b1;
    else if (|mins)    ports[3:0] = mins;
    else if (|der)     ports[3:0] = der;
    else               unroutable = 1'b1;
  end
endmodule

// File: rtl/lbdr_dr.sv
// LBDR routing unit for one input port: config registers, packet-lock FSM
// and registered port requests toward the switch allocator.
module lbdr_dr
  import lbdr_pkg::*;
#(
  parameter int X_W          = 2,
  parameter int Y_W          = 2,
  parameter bit DEROUTE_EN   = 1'b1,
  parameter int RST_CUR_ADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               empty,
  input  logic [2:0]         flit_id,
  input  logic [X_W+Y_W-1:0] dst_addr,
  input  logic [7:0]         Rxy_rst,
  input  logic [3:0]         Cx_rst,
  input  logic [3:0]         Dr_rst,
  input  logic [X_W+Y_W-1:0] cur_addr_rst,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_Rxy,
  input  logic [3:0]         cfg_Cx,
  input  logic [3:0]         cfg_Dr,
  output logic               cfg_busy,
  output logic               Nport,
  output logic               Eport,
  output logic               Wport,
  output logic               Sport,
  output logic               Lport,
  output logic               unroutable,
  output logic               err_orphan
);
  localparam int A_W = X_W + Y_W;

  logic [A_W-1:0] cur_addr = A_W'(RST_CUR_ADDR);
  logic [7:0]     rxy;
  logic [3:0]     cx, dr;
  state_t         state, state_n;
  logic [4:0]     port_q, port_n, r_ports;
  logic           unr_q, unr_n, orph_q, orph_n, r_unr;
  logic           accept, hdr;

  lbdr_route_comb #(.X_W(X_W), .Y_W(Y_W), .DEROUTE_EN(DEROUTE_EN)) u_route (
    .dst        (dst_addr),
    .cur        (cur_addr),
    .rxy        (rxy),
    .cx         (cx),
    .dr         (dr),
    .ports      (r_ports),
    .unroutable (r_unr)
  );

  assign accept = ~empty;
  assign hdr    = accept && (flit_id == HEADER);

  always_comb begin
    state_n = state;
    port_n  = port_q;
    unr_n   = 1'b0;
    orph_n  = 1'b0;
    // a header re-routes from any state; an unroutable one drops the lock
    if (hdr) begin
      port_n  = r_ports;
      unr_n   = r_unr;
      state_n = r_unr ? IDLE : HOLD;
    end else begin
      case (state)
        IDLE: if (accept && (flit_id == BODY || flit_id == TAIL)) begin
          orph_n = 1'b1;
          port_n = '0;
        end
        HOLD: if (accept && flit_id == TAIL) state_n = LAST;
        LAST: begin
          state_n = IDLE;
          port_n  = '0;
        end
        default: begin
          state_n = IDLE;
          port_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      port_q   <= '0;
      unr_q    <= 1'b0;
      orph_q   <= 1'b0;
      rxy      <= Rxy_rst;
      cx       <= Cx_rst;
      dr       <= Dr_rst;
      cur_addr <= cur_addr_rst;
    end else begin
      state  <= state_n;
      port_q <= port_n;
      unr_q  <= unr_n;
      orph_q <= orph_n;
      // the header in this cycle already used the old values
      if (cfg_we && state == IDLE) begin
        rxy <= cfg_Rxy;
        cx  <= cfg_Cx;
        dr  <= cfg_Dr;
      end
    end
  end

  assign cfg_busy   = (state != IDLE);
  assign Nport      = port_q[N];
  assign Eport      = port_q[E];
  assign Wport      = port_q[W];
  assign Sport      = port_q[S];
  assign Lport      = port_q[L];
  assign unroutable = unr_q;
  assign err_orphan = orph_q;
endmodule

// File: tb/tb_lbdr_dr.sv
// Directed bench for lbdr_dr: one instance with deroute, one without, fed
// the same flit stream; expected values are hand-derived for cur=5 (x=1,y=1).
module tb_lbdr_dr;
  import lbdr_pkg::*;

  logic       clk = 1'b0;
  logic       rst, empty, cfg_we;
  logic [2:0] flit_id;
  logic [3:0] dst_addr, cur_addr_rst, Cx_rst, Dr_rst, cfg_Cx, cfg_Dr;
  logic [7:0] Rxy_rst, cfg_Rxy;
  logic       busy_a, na, ea, wa, sa, la, unr_a, orph_a;
  logic       busy_b, nb, eb, wb, sb, lb, unr_b, orph_b;
  logic [4:0] pa, pb;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  assign pa = {la, sa, wa, ea, na};
  assign pb = {lb, sb, wb, eb, nb};

  lbdr_dr #(.X_W(2), .Y_W(2), .DEROUTE_EN(1'b1), .RST_CUR_ADDR(5)) dut_a (
    .clk(clk), .rst(rst), .empty(empty), .flit_id(flit_id), .dst_addr(dst_addr),
    .Rxy_rst(Rxy_rst), .Cx_rst(Cx_rst), .Dr_rst(Dr_rst), .cur_addr_rst(cur_addr_rst),
    .cfg_we(cfg_we), .cfg_Rxy(cfg_Rxy), .cfg_Cx(cfg_Cx), .cfg_Dr(cfg_Dr),
    .cfg_busy(busy_a), .Nport(na), .Eport(ea), .Wport(wa), .Sport(sa), .Lport(la),
    .unroutable(unr_a), .err_orphan(orph_a));

  lbdr_dr #(.X_W(2), .Y_W(2), .DEROUTE_EN(1'b0), .RST_CUR_ADDR(5)) dut_b (
    .clk(clk), .rst(rst), .empty(empty), .flit_id(flit_id), .dst_addr(dst_addr),
    .Rxy_rst(Rxy_rst), .Cx_rst(Cx_rst), .Dr_rst(Dr_rst), .cur_addr_rst(cur_addr_rst),
    .cfg_we(cfg_we), .cfg_Rxy(cfg_Rxy), .cfg_Cx(cfg_Cx), .cfg_Dr(cfg_Dr),
    .cfg_busy(busy_b), .Nport(nb), .Eport(eb), .Wport(wb), .Sport(sb), .Lport(lb),
    .unroutable(unr_b), .err_orphan(orph_b));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic e, input logic [2:0] f, input logic [3:0] d);
    empty    = e;
    flit_id  = f;
    dst_addr = d;
  endtask

  task automatic cfg(input logic [7:0] r, input logic [3:0] c, input logic [3:0] d);
    cfg_we  = 1'b1;
    cfg_Rxy = r;
    cfg_Cx  = c;
    cfg_Dr  = d;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_Rxy = 8'h00; cfg_Cx = 4'h0; cfg_Dr = 4'h0;
    Rxy_rst = 8'hFF; Cx_rst = 4'hF; Dr_rst = 4'hF; cur_addr_rst = 4'd5;
    drv(1'b1, 3'b000, 4'd0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_ports", {3'b0, pa}, 8'h00);
    chk("rst_busy", {7'b0, busy_a}, 8'h00);
    chk("rst_unr", {7'b0, unr_a}, 8'h00);
    chk("rst_orph", {7'b0, orph_a}, 8'h00);

    // north packet: header, body, stall, body, tail
    drv(1'b0, HEADER, 4'd1); tick();
    chk("hdr_north", {3'b0, pa}, 8'h01);
    chk("hdr_north_b", {3'b0, pb}, 8'h01);
    chk("hdr_busy", {7'b0, busy_a}, 8'h01);
    drv(1'b0, BODY, 4'd0); tick();
    chk("body_hold", {3'b0, pa}, 8'h01);
    drv(1'b1, BODY, 4'd0); tick();
    chk("empty_hold", {3'b0, pa}, 8'h01);
    drv(1'b0, BODY, 4'd0); tick();
    drv(1'b0, TAIL, 4'd0); tick();
    chk("last_hold", {3'b0, pa}, 8'h01);
    chk("last_busy", {7'b0, busy_a}, 8'h01);
    drv(1'b1, 3'b000, 4'd0); tick();
    chk("idle_clear", {3'b0, pa}, 8'h00);
    chk("idle_busy", {7'b0, busy_a}, 8'h00);

    // Rxy=3C: south-east dst uses Res only
    cfg(8'h3C, 4'hF, 4'hF); tick();
    cfg_we = 1'b0;
    drv(1'b0, HEADER, 4'd10); tick();
    chk("se_east_only", {3'b0, pa}, 8'h02);
    drv(1'b0, TAIL, 4'd0); tick();
    drv(1'b1, 3'b000, 4'd0); tick();
    chk("se_done", {3'b0, pa}, 8'h00);

    // header in the same cycle as cfg_we routes with old config
    cfg(8'hFF, 4'b1110, 4'b0010);
    drv(1'b0, HEADER, 4'd1); tick();
    cfg_we = 1'b0;
    chk("cfg_same_cycle", {3'b0, pa}, 8'h01);
    cfg(8'hFF, 4'h0, 4'h0);
    drv(1'b1, 3'b000, 4'd0); tick();
    cfg_we = 1'b0;
    chk("cfg_hold_busy", {7'b0, busy_a}, 8'h01);
    chk("cfg_hold_ports", {3'b0, pa}, 8'h01);
    // re-route in HOLD; Cn=0 so deroute to E (config write above was ignored)
    drv(1'b0, HEADER, 4'd1); tick();
    chk("deroute_east", {3'b0, pa}, 8'h02);
    chk("reroute_no_unr", {7'b0, unr_a}, 8'h00);
    chk("reroute_no_orph", {7'b0, orph_a}, 8'h00);
    chk("noder_ports", {3'b0, pb}, 8'h00);
    chk("noder_unr", {7'b0, unr_b}, 8'h01);
    drv(1'b0, TAIL, 4'd0); tick();
    drv(1'b1, 3'b000, 4'd0); tick();
    chk("der_done", {3'b0, pa}, 8'h00);

    // orphan body in IDLE
    drv(1'b0, BODY, 4'd0); tick();
    chk("orph_pulse", {7'b0, orph_a}, 8'h01);
    chk("orph_ports", {3'b0, pa}, 8'h00);
    drv(1'b1, 3'b000, 4'd0); tick();
    chk("orph_one_cycle", {7'b0, orph_a}, 8'h00);

    // Dr=0 with Cn=0: nothing legal
    cfg(8'hFF, 4'b1110, 4'b0000); tick();
    cfg_we = 1'b0;
    drv(1'b0, HEADER, 4'd1); tick();
    chk("unr_pulse", {7'b0, unr_a}, 8'h01);
    chk("unr_ports", {3'b0, pa}, 8'h00);
    chk("unr_idle", {7'b0, busy_a}, 8'h00);
    drv(1'b1, 3'b000, 4'd0); tick();
    chk("unr_one_cycle", {7'b0, unr_a}, 8'h00);

    // Cx=0 written in IDLE makes the next header unroutable
    cfg(8'hFF, 4'h0, 4'hF); tick();
    cfg_we = 1'b0;
    drv(1'b0, HEADER, 4'd10); tick();
    chk("cx0_unr_a", {7'b0, unr_a}, 8'h01);
    chk("cx0_unr_b", {7'b0, unr_b}, 8'h01);
    chk("cx0_ports_b", {3'b0, pb}, 8'h00);

    // reset reloads config, then reset mid-packet
    rst = 1'b1; drv(1'b1, 3'b000, 4'd0); tick();
    rst = 1'b0;
    drv(1'b0, HEADER, 4'd1); tick();
    chk("reload_north", {3'b0, pa}, 8'h01);
    drv(1'b0, BODY, 4'd0); tick();
    rst = 1'b1; drv(1'b1, 3'b000, 4'd0); tick();
    rst = 1'b0;
    chk("midrst_ports", {3'b0, pa}, 8'h00);
    chk("midrst_busy", {7'b0, busy_a}, 8'h00);

    // local delivery, then header in LAST goes straight to HOLD
    drv(1'b0, HEADER, 4'd5); tick();
    chk("local", {3'b0, pa}, 8'h10);
    drv(1'b0, TAIL, 4'd0); tick();
    drv(1'b0, HEADER, 4'd10); tick();
    chk("last_reroute", {3'b0, pa}, 8'h0A);
    drv(1'b1, 3'b000, 4'd0); tick();
    chk("last_to_hold", {3'b0, pa}, 8'h0A);
    chk("last_to_hold_busy", {7'b0, busy_a}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
